vector_scalar_operand_sequencer: RTL and testbench
==================================================

Name: vector_scalar_operand_sequencer

Overview:
Controller that broadcasts one scalar operand across all active elements of a vector instruction, one element per cycle, to the lane datapath.
- Operand source is a 64-bit scalar register or a 5-bit immediate, extended to 64 bits by sign or zero extension.
- Sits between the vector issue stage (request side) and the lane operand port (element side).
- Handles vector-scalar and vector-immediate instruction forms.

Parameters:
VL_WIDTH, 7, width of the vector-length input and the element counter; maximum VL is 2^VL_WIDTH-1.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
req_valid_i  input  1  issue stage presents a request.
req_ready_o  output  1  sequencer can accept a request.
operand_src_i  input  2  00 = scalar register, 01 = imm5 sign-extended, 10 = imm5 zero-extended, 11 = reserved.
imm5_i  input  5  immediate field.
scalar_i  input  64  scalar register value.
vl_i  input  VL_WIDTH  number of active elements.
flush_i  input  1  abort current instruction.
elem_valid_o  output  1  element operand valid.
elem_ready_i  input  1  lane accepts element.
elem_data_o  output  64  broadcast operand.
elem_idx_o  output  VL_WIDTH  element index.
elem_last_o  output  1  current element is index vl-1.
done_o  output  1  one-cycle completion pulse.
error_o  output  1  one-cycle pulse on reserved operand_src.
busy_o  output  1  high while in ISSUE.

Behaviour:
- States: IDLE, ISSUE.
- All outputs are registered.
- Reset (rst_i=1 at an edge):
  - state=IDLE.
  - req_ready_o=1 on the cycle after reset deasserts; held 0 while rst_i=1.
  - All other outputs = 0, including elem_data_o and elem_idx_o.
  - Reset mid-ISSUE drops the instruction; no done_o.
- req_ready_o=1 exactly when state=IDLE. Accept = req_valid_i & req_ready_o.
- Accept with operand_src_i=11:
  - No state change.
  - error_o=1 for the next cycle only.
  - Request consumed; no elements issued.
- Accept with vl_i=0:
  - Stay IDLE.
  - done_o=1 for the next cycle; no elements issued.
- Accept otherwise:
  - Latch operand:
    - 00 -> scalar_i.
    - 01 -> {59{imm5_i[4]}, imm5_i}.
    - 10 -> {59'b0, imm5_i}.
  - Latch vl_i; counter=0; go to ISSUE.
  - elem_valid_o=1 in the cycle after the accept edge (latency 1).
- ISSUE:
  - elem_valid_o=1; elem_data_o=latched operand; elem_idx_o=counter; elem_last_o=(counter==vl-1); busy_o=1.
  - elem_valid_o & !elem_ready_i: all element outputs hold stable.
  - Handshake on non-last element: counter+1.
  - Handshake on last element: next cycle state=IDLE, elem_valid_o=0, done_o=1 (one cycle), req_ready_o=1.
  - A new request may be accepted in that done_o cycle.
- Counter never wraps: the maximum vl = 2^VL_WIDTH-1 ends at index vl-1.
- flush_i=1 in ISSUE:
  - Next cycle IDLE; elem_valid_o=0; no done_o.
  - flush_i overrides a same-cycle handshake.
- flush_i=1 in IDLE: ignored, including when coincident with an accept.
- rst_i has priority over flush_i, which has priority over handshake.
- done_o and error_o are never high together.

Test Plan:
- operand_src=01, imm5=5'b10110, vl=4, elem_ready_i=1 -> elem_data_o=0xFFFF_FFFF_FFFF_FFF6 for idx 0..3 on consecutive cycles; elem_last_o on idx 3; done_o one cycle later; req_ready_o=0 throughout ISSUE.
- operand_src=10, imm5=5'b10110, vl=2 -> elem_data_o=0x0000_0000_0000_0016 for idx 0,1; operand_src=00, scalar=0x1234_5678_9ABC_DEF0, vl=1 -> single element, elem_last_o=1, done_o.
- vl=3 with elem_ready_i low on cycles 2 and 3 -> idx, data and last hold stable; exactly 3 handshakes; done_o after the third.
- vl=0 -> no elem_valid_o, done_o pulse next cycle; operand_src=11 -> error_o pulse, no elem_valid_o, no done_o.
- vl=127, operand_src=01, imm5=5'b01111 -> data=0xF on all 127 elements; idx 0..126; last at 126; no wrap; back-to-back request accepted in the done_o cycle starts at idx 0.
- flush_i at idx 2 of vl=8 -> elem_valid_o=0 next cycle, no done_o; rst_i at idx 5 of another run -> all outputs 0, req_ready_o=1 after release.

Source files
------------

// File: rtl/vector_scalar_operand_sequencer.sv
// Broadcasts one scalar/immediate operand to every active element of a vector
// instruction, one element per accepted lane handshake.
module vector_scalar_operand_sequencer #(
  parameter int unsigned VL_WIDTH = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          operand_src_i,
  input  logic [4:0]          imm5_i,
  input  logic [63:0]         scalar_i,
  input  logic [VL_WIDTH-1:0] vl_i,
  input  logic                flush_i,
  output logic                elem_valid_o,
  input  logic                elem_ready_i,
  output logic [63:0]         elem_data_o,
  output logic [VL_WIDTH-1:0] elem_idx_o,
  output logic                elem_last_o,
  output logic                done_o,
  output logic                error_o,
  output logic                busy_o
);

  localparam int unsigned DATA_W = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [1:0] SRC_SCALAR = 2'b00;
  localparam logic [1:0] SRC_SEXT   = 2'b01;
  localparam logic [1:0] SRC_ZEXT   = 2'b10;

  state_t              state_q, state_d;
  logic [VL_WIDTH-1:0] vl_q, vl_d;
  logic [VL_WIDTH-1:0] idx_d, idx_nxt;
  logic [DATA_W-1:0]   data_d;
  logic                valid_d, last_d, done_d, error_d;
  logic                accept;

  assign accept  = req_valid_i & req_ready_o;
  assign idx_nxt = VL_WIDTH'(elem_idx_o + 1'b1);

  // State register and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      vl_q         <= '0;
      req_ready_o  <= 1'b0;
      elem_valid_o <= 1'b0;
      elem_data_o  <= '0;
      elem_idx_o   <= '0;
      elem_last_o  <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vl_q         <= vl_d;
      req_ready_o  <= (state_d == IDLE);
      elem_valid_o <= valid_d;
      elem_data_o  <= data_d;
      elem_idx_o   <= idx_d;
      elem_last_o  <= last_d;
      done_o       <= done_d;
      error_o      <= error_d;
      busy_o       <= (state_d == ISSUE);
    end
  end

  // Next-state and next-output logic; flush outranks the element handshake
  always_comb begin
    state_d = state_q;
    vl_d    = vl_q;
    data_d  = elem_data_o;
    idx_d   = elem_idx_o;
    valid_d = elem_valid_o;
    last_d  = elem_last_o;
    done_d  = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (accept) begin
          if (operand_src_i == 2'b11) begin
            error_d = 1'b1;
          end else if (vl_i == '0) begin
            done_d = 1'b1;
          end else begin
            unique case (operand_src_i)
              SRC_SCALAR: data_d = scalar_i;
              SRC_SEXT:   data_d = {{59{imm5_i[4]}}, imm5_i};
              SRC_ZEXT:   data_d = {59'b0, imm5_i};
              default:    data_d = elem_data_o;
            endcase
            vl_d    = vl_i;
            idx_d   = '0;
            last_d  = (vl_i == VL_WIDTH'(1));
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (flush_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (elem_ready_i) begin
          if (elem_last_o) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            last_d = (idx_nxt == VL_WIDTH'(vl_q - 1'b1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_scalar_operand_sequencer.sv
// Directed bench for vector_scalar_operand_sequencer with hand-computed expectations.
module tb_vector_scalar_operand_sequencer;

  localparam int unsigned VL_WIDTH = 7;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [1:0]          operand_src_i = 2'b00;
  logic [4:0]          imm5_i = '0;
  logic [63:0]         scalar_i = '0;
  logic [VL_WIDTH-1:0] vl_i = '0;
  logic                flush_i = 1'b0;
  logic                elem_valid_o;
  logic                elem_ready_i = 1'b1;
  logic [63:0]         elem_data_o;
  logic [VL_WIDTH-1:0] elem_idx_o;
  logic                elem_last_o;
  logic                done_o;
  logic                error_o;
  logic                busy_o;

  int total = 0;
  int bad   = 0;

  vector_scalar_operand_sequencer #(.VL_WIDTH(VL_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .operand_src_i(operand_src_i), .imm5_i(imm5_i), .scalar_i(scalar_i),
    .vl_i(vl_i), .flush_i(flush_i),
    .elem_valid_o(elem_valid_o), .elem_ready_i(elem_ready_i),
    .elem_data_o(elem_data_o), .elem_idx_o(elem_idx_o), .elem_last_o(elem_last_o),
    .done_o(done_o), .error_o(error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request for a single cycle; returns in the cycle after the accept edge
  task automatic send(input logic [1:0] src, input logic [4:0] imm, input logic [63:0] sc,
                      input int vl, input logic fl);
    req_valid_i   = 1'b1;
    operand_src_i = src;
    imm5_i        = imm;
    scalar_i      = sc;
    vl_i          = VL_WIDTH'(vl);
    flush_i       = fl;
    step();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  // Walk the element stream; stall[c]=1 drops elem_ready_i in stream cycle c
  task automatic run_stream(input string tag, input logic [63:0] d, input int vl,
                            input logic [15:0] stall);
    int idx = 0;
    int cyc = 0;
    int hs  = 0;
    logic [15:0] st;
    st = stall;
    while (idx < vl && cyc < 1000) begin
      elem_ready_i = (cyc < 16) ? !st[cyc] : 1'b1;
      chk({tag, " valid"}, 64'(elem_valid_o), 64'd1);
      chk({tag, " idx"},   64'(elem_idx_o), 64'(idx));
      chk({tag, " data"},  elem_data_o, d);
      chk({tag, " last"},  64'(elem_last_o), 64'(idx == vl - 1));
      chk({tag, " busy"},  64'(busy_o), 64'd1);
      chk({tag, " rdy"},   64'(req_ready_o), 64'd0);
      chk({tag, " done"},  64'(done_o), 64'd0);
      if (elem_ready_i) begin
        idx++;
        hs++;
      end
      step();
      cyc++;
    end
    elem_ready_i = 1'b1;
    chk({tag, " handshakes"}, 64'(hs), 64'(vl));
    chk({tag, " done"},   64'(done_o), 64'd1);
    chk({tag, " valid0"}, 64'(elem_valid_o), 64'd0);
    chk({tag, " rdy1"},   64'(req_ready_o), 64'd1);
    chk({tag, " busy0"},  64'(busy_o), 64'd0);
    chk({tag, " err0"},   64'(error_o), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " valid"}, 64'(elem_valid_o), 64'd0);
    chk({tag, " done"},  64'(done_o), 64'd0);
    chk({tag, " err"},   64'(error_o), 64'd0);
    chk({tag, " busy"},  64'(busy_o), 64'd0);
    chk({tag, " rdy"},   64'(req_ready_o), 64'd1);
  endtask

  initial begin
    // Reset values, held ready low while in reset
    step();
    step();
    chk("rst rdy",   64'(req_ready_o), 64'd0);
    chk("rst valid", 64'(elem_valid_o), 64'd0);
    chk("rst data",  elem_data_o, 64'd0);
    chk("rst idx",   64'(elem_idx_o), 64'd0);
    chk("rst last",  64'(elem_last_o), 64'd0);
    chk("rst done",  64'(done_o), 64'd0);
    chk("rst err",   64'(error_o), 64'd0);
    chk("rst busy",  64'(busy_o), 64'd0);
    rst_i = 1'b0;
    step();
    chk_quiet("post rst");

    // Sign-extended immediate, vl=4
    send(2'b01, 5'b10110, 64'h0, 4, 1'b0);
    run_stream("sext4", 64'hFFFF_FFFF_FFFF_FFF6, 4, 16'h0000);
    step();
    chk_quiet("after sext4");

    // Zero-extended immediate, vl=2
    send(2'b10, 5'b10110, 64'h0, 2, 1'b0);
    run_stream("zext2", 64'h0000_0000_0000_0016, 2, 16'h0000);
    step();

    // Scalar operand, single element
    send(2'b00, 5'b0, 64'h1234_5678_9ABC_DEF0, 1, 1'b0);
    run_stream("scalar1", 64'h1234_5678_9ABC_DEF0, 1, 16'h0000);
    step();

    // Back-pressure on 2nd and 3rd stream cycles
    send(2'b00, 5'b0, 64'hDEAD_BEEF_0000_0003, 3, 1'b0);
    run_stream("stall3", 64'hDEAD_BEEF_0000_0003, 3, 16'b0000_0000_0000_0110);
    step();

    // vl=0 completes immediately
    send(2'b00, 5'b0, 64'h55, 0, 1'b0);
    chk("vl0 done",  64'(done_o), 64'd1);
    chk("vl0 valid", 64'(elem_valid_o), 64'd0);
    chk("vl0 err",   64'(error_o), 64'd0);
    chk("vl0 rdy",   64'(req_ready_o), 64'd1);
    step();
    chk_quiet("after vl0");

    // Reserved source raises error only
    send(2'b11, 5'b00001, 64'h0, 4, 1'b0);
    chk("rsv err",   64'(error_o), 64'd1);
    chk("rsv done",  64'(done_o), 64'd0);
    chk("rsv valid", 64'(elem_valid_o), 64'd0);
    chk("rsv rdy",   64'(req_ready_o), 64'd1);
    step();
    chk_quiet("after rsv");

    // Maximum vl, then a back-to-back request in the done cycle
    send(2'b01, 5'b01111, 64'h0, 127, 1'b0);
    run_stream("max127", 64'h0000_0000_0000_000F, 127, 16'h0000);
    send(2'b10, 5'b00011, 64'h0, 2, 1'b0);
    run_stream("b2b", 64'h3, 2, 16'h0000);
    step();

    // Flush coincident with an accept in IDLE is ignored
    send(2'b10, 5'b00111, 64'h0, 1, 1'b1);
    run_stream("idle flush", 64'h7, 1, 16'h0000);
    step();

    // Flush at idx 2 of vl=8
    send(2'b00, 5'b0, 64'hA5A5, 8, 1'b0);
    step();
    step();
    chk("fl idx2", 64'(elem_idx_o), 64'd2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_quiet("flush");
    step();
    chk_quiet("flush+1");

    // Reset at idx 5 of vl=10
    send(2'b00, 5'b0, 64'hCAFE, 10, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("rm idx5", 64'(elem_idx_o), 64'd5);
    rst_i = 1'b1;
    flush_i = 1'b1;
    step();
    rst_i = 1'b0;
    flush_i = 1'b0;
    chk("rm valid", 64'(elem_valid_o), 64'd0);
    chk("rm data",  elem_data_o, 64'd0);
    chk("rm idx",   64'(elem_idx_o), 64'd0);
    chk("rm done",  64'(done_o), 64'd0);
    chk("rm busy",  64'(busy_o), 64'd0);
    chk("rm rdy",   64'(req_ready_o), 64'd0);
    step();
    chk_quiet("rm release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
